tdm_demux: RTL and testbench
============================

# tdm_demux

Time-division demultiplexer: the receive end of a serial sample stream built by interleaving NCH channels through a select-driven mux. It locks onto a channel-0 sync marker, then routes each valid sample to its channel's output register. It raises a per-channel valid strobe and a frame-complete strobe. It sits after the channel mux/serial link and feeds per-channel processing.

## Interface
- NCH, default 4: number of channels; must be ≥ 2; slot counter width is clog2(NCH).
- W, default 8: sample width in bits.
- ERRW, default 8: width of the sync error counter.

- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset, synchronous, active-high; the only reset.
- in_valid  input  1  in_data/in_sync are meaningful this cycle.
- in_data  input  W  sample.
- in_sync  input  1  marks the current sample as channel 0; ignored when in_valid=0.
- out_data  output  NCH*W  channel i sample at bits [i*W +: W]; held until overwritten.
- out_valid  output  NCH  bit i pulses high for 1 cycle when channel i is updated.
- frame_valid  output  1  1-cycle pulse: channel NCH-1 written while locked.
- locked  output  1  high in state LOCKED.
- sync_err  output  1  1-cycle pulse on a sync violation.
- err_cnt  output  ERRW  saturating count of sync_err pulses.

## Operation
- State machine has two states:
  - HUNT: discard samples until an accepted sample has in_sync=1.
  - LOCKED: route samples to channel slot.
- Accepted sample: a cycle with in_valid=1. Cycles with in_valid=0 change nothing: slot, state and outputs all hold, except that strobes deassert.
- HUNT, accepted sample with sync=1: write to channel 0, set slot=1, go to LOCKED.
- HUNT, accepted sample with sync=0: drop the sample; no sync_err.
- LOCKED, sample with sync=0 and slot≠0: write to channel slot. slot = slot+1, wrapping from NCH-1 to 0.
- LOCKED, sample with sync=1 and slot=0: normal frame start. Write to channel 0, set slot=1.
- LOCKED, sample with sync=1 and slot≠0 (early sync): pulse sync_err and realign. Write the sample to channel 0, set slot=1, stay in LOCKED.
- LOCKED, sample with sync=0 and slot=0 (missing sync): pulse sync_err, drop the sample, set slot=0, go to HUNT.
- frame_valid pulses alongside out_valid[NCH-1] on every LOCKED write to slot NCH-1.
- err_cnt increments on each sync_err and saturates at 2^ERRW-1; it clears only on rst.
- On a write, out_data for the other channels is unchanged.
- No backpressure: the block must accept one sample every cycle indefinitely.

## Timing
- Latency is 1 cycle: a sample accepted at edge k appears on out_data with its out_valid bit, frame_valid and sync_err after edge k.
- All outputs are registered. Strobes are high for exactly one cycle per event. At most one out_valid bit is high in any cycle.
- Back-to-back accepted samples give strobes in consecutive cycles with no bubble.
- Reset values: out_data=0, out_valid=0, frame_valid=0, locked=0, sync_err=0, err_cnt=0, state=HUNT, slot=0.
- rst asserted mid-frame: at the next edge every register takes its reset value and the sample presented that cycle is discarded. The first sample after rst deasserts is handled in HUNT.
- rst has priority over in_valid in the same cycle.
- locked goes high in the cycle after the locking sample, together with out_valid[0]. It goes low in the cycle after a missing-sync sample, together with sync_err.

## Test plan
- Reset and hunt (NCH=4, W=8): rst 2 cycles, then samples 0x11, 0x22 (no sync), then 0xA0 with sync, 0xA1, 0xA2, 0xA3. Required:
  - 0x11 and 0x22 dropped, locked=0, sync_err=0.
  - Channels 0..3 = A0..A3, out_valid one-hot in order 1,2,4,8.
  - frame_valid with the 0xA3 strobe; locked=1 from the 0xA0 strobe.
- Gaps: same frame with in_valid=0 for 3 cycles between every sample. Required: identical channel contents; no strobes during gaps; slot holds across gaps.
- Early sync: lock, send B0, B1, then C0 with sync, then C1..C3. Required:
  - sync_err pulse on C0, err_cnt=1.
  - ch0=C0, ch1=C1, ch2=C2, ch3=C3; frame_valid with C3; locked stays 1.
  - ch2 keeps its old value until C2 arrives.
- Missing sync: after a complete frame, send 0x55 with sync=0. Required:
  - sync_err pulse, locked=0, no out_valid, 0x55 dropped.
  - The next sync sample relocks to ch0.
- Reset mid-frame: after a sync and 2 samples, assert rst for 1 cycle while in_valid=1. Required: all outputs 0, err_cnt=0, locked=0, and that sample not written.
- Saturation (ERRW=2): 5 consecutive missing-sync events, each preceded by a relock. Required: err_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/tdm_demux_if.sv
// Bundle of the serial sample input and the per-channel output bus of tdm_demux.
// The master drives samples in; the slave (the demux) drives the channel outputs.
interface tdm_demux_if #(
    parameter int NCH  = 4,
    parameter int W    = 8,
    parameter int ERRW = 8
);
    logic                in_valid;
    logic [W-1:0]        in_data;
    logic                in_sync;
    logic [NCH*W-1:0]    out_data;
    logic [NCH-1:0]      out_valid;
    logic                frame_valid;
    logic                locked;
    logic                sync_err;
    logic [ERRW-1:0]     err_cnt;

    modport master (
        output in_valid, in_data, in_sync,
        input  out_data, out_valid, frame_valid, locked, sync_err, err_cnt
    );

    modport slave (
        input  in_valid, in_data, in_sync,
        output out_data, out_valid, frame_valid, locked, sync_err, err_cnt
    );
endinterface

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: locks onto the channel-0 sync marker and steers
// each accepted sample to its channel register with 1-cycle registered latency.
module tdm_demux #(
    parameter int NCH  = 4,
    parameter int W    = 8,
    parameter int ERRW = 8
) (
    input  logic       clk,
    input  logic       rst,
    tdm_demux_if.slave bus
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   slot_reg, slot_next;
    logic            wr_en_next;
    logic [SW-1:0]   wr_ch_next;
    logic            err_next;

    logic [W-1:0]    data_reg [NCH];
    logic [NCH-1:0]  out_valid_reg;
    logic            frame_valid_reg;
    logic            sync_err_reg;
    logic [ERRW-1:0] err_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= HUNT;
            slot_reg  <= '0;
        end else begin
            state_reg <= state_next;
            slot_reg  <= slot_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        wr_en_next = 1'b0;
        wr_ch_next = '0;
        err_next   = 1'b0;
        if (bus.in_valid) begin
            case (state_reg)
                HUNT: begin
                    if (bus.in_sync) begin
                        wr_en_next = 1'b1;
                        slot_next  = SW'(1);
                        state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    if (bus.in_sync) begin
                        // A sync mid-frame realigns rather than dropping lock.
                        err_next   = (slot_reg != '0);
                        wr_en_next = 1'b1;
                        slot_next  = SW'(1);
                    end else if (slot_reg != '0) begin
                        wr_en_next = 1'b1;
                        wr_ch_next = slot_reg;
                        slot_next  = (slot_reg == SW'(NCH - 1)) ? '0 : slot_reg + SW'(1);
                    end else begin
                        err_next   = 1'b1;
                        slot_next  = '0;
                        state_next = HUNT;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg[gi]      <= '0;
                    out_valid_reg[gi] <= 1'b0;
                end else begin
                    out_valid_reg[gi] <= wr_en_next && (wr_ch_next == SW'(gi));
                    if (wr_en_next && (wr_ch_next == SW'(gi)))
                        data_reg[gi] <= bus.in_data;
                end
            end
            assign bus.out_data[gi*W +: W] = data_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
            err_cnt_reg     <= '0;
        end else begin
            frame_valid_reg <= wr_en_next && (wr_ch_next == SW'(NCH - 1));
            sync_err_reg    <= err_next;
            if (err_next && (err_cnt_reg != {ERRW{1'b1}}))
                err_cnt_reg <= err_cnt_reg + ERRW'(1);
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.sync_err    = sync_err_reg;
    assign bus.err_cnt     = err_cnt_reg;
    assign bus.locked      = (state_reg == LOCKED);
endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: a behavioural model predicts every cycle's
// outputs, which are queued on drive and compared after the next rising edge.
module tb_tdm_demux;
    localparam int NCH  = 4;
    localparam int W    = 8;
    localparam int ERRW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdm_demux_if #(.NCH(NCH), .W(W), .ERRW(ERRW)) bus ();
    tdm_demux #(.NCH(NCH), .W(W), .ERRW(ERRW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [NCH*W-1:0] data;
        logic [NCH-1:0]   ov;
        logic             fv;
        logic             se;
        logic             lk;
        logic [ERRW-1:0]  ec;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int txn   = 0;

    logic         m_locked;
    int           m_slot;
    int           m_err;
    logic [W-1:0] m_ch [NCH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic s, input logic [W-1:0] d);
        exp_t e;
        logic se;
        rst = r;
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.in_data  = d;
        e.ov = '0;
        e.fv = 1'b0;
        se   = 1'b0;
        if (r) begin
            m_locked = 1'b0;
            m_slot   = 0;
            m_err    = 0;
            for (int i = 0; i < NCH; i++) m_ch[i] = '0;
        end else if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_ch[0] = d; e.ov = 1; m_slot = 1; m_locked = 1'b1;
                end
            end else if (s) begin
                se = (m_slot != 0);
                m_ch[0] = d; e.ov = 1; m_slot = 1;
            end else if (m_slot != 0) begin
                m_ch[m_slot] = d;
                e.ov = NCH'(1) << m_slot;
                e.fv = (m_slot == NCH - 1);
                m_slot = (m_slot + 1) % NCH;
            end else begin
                se = 1'b1; m_locked = 1'b0;
            end
            if (se && m_err < (2 ** ERRW) - 1) m_err++;
        end
        e.se = se;
        e.lk = m_locked;
        e.ec = ERRW'(m_err);
        for (int i = 0; i < NCH; i++) e.data[i*W +: W] = m_ch[i];
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("out_data",    32'(bus.out_data),    32'(e.data));
        chk("out_valid",   32'(bus.out_valid),   32'(e.ov));
        chk("frame_valid", 32'(bus.frame_valid), 32'(e.fv));
        chk("sync_err",    32'(bus.sync_err),    32'(e.se));
        chk("locked",      32'(bus.locked),      32'(e.lk));
        chk("err_cnt",     32'(bus.err_cnt),     32'(e.ec));
        txn++;
        $display("txn %0d rst=%b v=%b s=%b d=%h -> data=%h ov=%b fv=%b se=%b lk=%b ec=%0d",
                 txn, r, v, s, d, bus.out_data, bus.out_valid, bus.frame_valid,
                 bus.sync_err, bus.locked, bus.err_cnt);
    endtask

    task automatic frame(input logic [W-1:0] base, input int gap);
        for (int i = 0; i < NCH; i++) begin
            step(1'b0, 1'b1, (i == 0), base + W'(i));
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b1, W'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_data  = '0;

        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // Hunt then lock
        step(1'b0, 1'b1, 1'b0, 8'h11);
        step(1'b0, 1'b1, 1'b0, 8'h22);
        chk("hunt_lock", 32'(bus.locked), 32'h0);
        frame(8'hA0, 0);
        chk("hunt_ch", 32'(bus.out_data), 32'hA3A2A1A0);

        // Gaps between samples
        frame(8'hA0, 3);
        chk("gap_ch", 32'(bus.out_data), 32'hA3A2A1A0);

        // Early sync
        step(1'b0, 1'b1, 1'b1, 8'hB0);
        step(1'b0, 1'b1, 1'b0, 8'hB1);
        step(1'b0, 1'b1, 1'b1, 8'hC0);
        chk("early_err", 32'(bus.sync_err), 32'h1);
        step(1'b0, 1'b1, 1'b0, 8'hC1);
        chk("ch2_hold", 32'(bus.out_data[23:16]), 32'hA2);
        step(1'b0, 1'b1, 1'b0, 8'hC2);
        step(1'b0, 1'b1, 1'b0, 8'hC3);
        chk("early_ch", 32'(bus.out_data), 32'hC3C2C1C0);
        chk("early_cnt", 32'(bus.err_cnt), 32'h1);
        chk("early_lock", 32'(bus.locked), 32'h1);

        // Missing sync
        step(1'b0, 1'b1, 1'b0, 8'h55);
        chk("miss_lock", 32'(bus.locked), 32'h0);
        chk("miss_ch", 32'(bus.out_data), 32'hC3C2C1C0);
        chk("miss_cnt", 32'(bus.err_cnt), 32'h2);
        step(1'b0, 1'b1, 1'b1, 8'hD0);
        chk("relock_ch0", 32'(bus.out_data[7:0]), 32'hD0);
        chk("relock_lk", 32'(bus.locked), 32'h1);

        // Reset mid-frame with a valid sample present
        step(1'b0, 1'b1, 1'b1, 8'hE0);
        step(1'b0, 1'b1, 1'b0, 8'hE1);
        step(1'b0, 1'b1, 1'b0, 8'hE2);
        step(1'b1, 1'b1, 1'b0, 8'hE3);
        chk("rst_data", 32'(bus.out_data), 32'h0);
        chk("rst_cnt", 32'(bus.err_cnt), 32'h0);
        step(1'b0, 1'b1, 1'b0, 8'h77);
        chk("post_rst_ov", 32'(bus.out_valid), 32'h0);

        // Error counter saturation
        for (int k = 0; k < 5; k++) begin
            logic [31:0] want [5];
            want = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3};
            frame(8'h40 + W'(k * 16), 0);
            step(1'b0, 1'b1, 1'b0, 8'h99);
            chk("sat_cnt", 32'(bus.err_cnt), want[k]);
        end

        step(1'b0, 1'b0, 1'b0, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
